// File: rtl/si_tag_pkg.sv
// Shared tag record and widths for the tag lane scheduler.
package si_tag_pkg;

   localparam int unsigned TAGTIME_WIDTH = 64;
   localparam int unsigned CHANNEL_WIDTH = 5;

   typedef struct packed {
      logic [TAGTIME_WIDTH-1:0] tagtime;
      logic [CHANNEL_WIDTH-1:0] channel;
      logic                     rising_edge;
   } tag_t;

endpackage

// File: rtl/si_lowest_bit_enc.sv
// Lowest-set-bit encoder: binary index, any-set flag and one-hot isolate.
module si_lowest_bit_enc #(
   parameter int unsigned WIDTH       = 4,
   parameter int unsigned INDEX_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic [WIDTH-1:0]       in_bits,
   output logic [INDEX_WIDTH-1:0] index,
   output logic                   any,
   output logic [WIDTH-1:0]       onehot
);

   // Scan from the top so the lowest set bit is the last one written.
   always_comb begin
      index = '0;
      for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
         if (in_bits[i]) begin
            index = INDEX_WIDTH'(i);
         end
      end
   end

   assign any    = |in_bits;
   assign onehot = in_bits & (~in_bits + WIDTH'(1));

endmodule

// File: rtl/si_tag_lane_scheduler.sv
// Buffers one multi-lane tag beat and emits its qualified lanes one per cycle,
// lowest lane first, with channel and edge-polarity filtering applied at load.
module si_tag_lane_scheduler
   import si_tag_pkg::*;
#(
   parameter int unsigned NUMBER_OF_WORDS = 4,
   parameter int unsigned CHANNEL_COUNT   = 20,
   parameter int unsigned LANE_WIDTH      = (NUMBER_OF_WORDS > 1) ? $clog2(NUMBER_OF_WORDS) : 1
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic                                     s_axis_tvalid,
   output logic                                     s_axis_tready,
   input  logic [TAGTIME_WIDTH*NUMBER_OF_WORDS-1:0] s_axis_tagtime,
   input  logic [CHANNEL_WIDTH*NUMBER_OF_WORDS-1:0] s_axis_channel,
   input  logic [NUMBER_OF_WORDS-1:0]               s_axis_rising_edge,
   input  logic [NUMBER_OF_WORDS-1:0]               s_axis_tkeep,
   input  logic [CHANNEL_COUNT-1:0]                 channel_enable,
   input  logic                                     rising_enable,
   input  logic                                     falling_enable,
   output logic                                     m_axis_tvalid,
   input  logic                                     m_axis_tready,
   output logic [TAGTIME_WIDTH-1:0]                 m_axis_tagtime,
   output logic [CHANNEL_WIDTH-1:0]                 m_axis_channel,
   output logic                                     m_axis_rising_edge,
   output logic [LANE_WIDTH-1:0]                    m_axis_lane,
   output logic [31:0]                              tag_count
);

   localparam int unsigned NW = NUMBER_OF_WORDS;

   tag_t             beat     [NW];
   tag_t             in_tag   [NW];
   logic [NW-1:0]    pending;
   logic [NW-1:0]    qualified;
   logic [NW-1:0]    sel_onehot;
   logic [31:0]      chan_en_ext;
   logic             sel_any;
   logic             single_pending;
   logic             load;
   logic             emit;

   assign chan_en_ext = 32'(channel_enable);

   // Unpack the input beat and evaluate the filters against the current controls.
   always_comb begin
      logic [CHANNEL_WIDTH-1:0] ch;
      ch        = '0;
      qualified = '0;
      for (int i = 0; i < int'(NW); i++) begin
         ch                    = s_axis_channel[i*CHANNEL_WIDTH +: CHANNEL_WIDTH];
         in_tag[i].tagtime     = s_axis_tagtime[i*TAGTIME_WIDTH +: TAGTIME_WIDTH];
         in_tag[i].channel     = ch;
         in_tag[i].rising_edge = s_axis_rising_edge[i];
         qualified[i] = s_axis_tkeep[i]
                      && (32'(ch) < CHANNEL_COUNT)
                      && chan_en_ext[ch]
                      && (s_axis_rising_edge[i] ? rising_enable : falling_enable);
      end
   end

   si_lowest_bit_enc #(
      .WIDTH       (NW),
      .INDEX_WIDTH (LANE_WIDTH)
   ) u_sel (
      .in_bits (pending),
      .index   (m_axis_lane),
      .any     (sel_any),
      .onehot  (sel_onehot)
   );

   assign single_pending = sel_any && ((pending & (pending - NW'(1))) == '0);
   assign s_axis_tready  = !rst && (!sel_any || (m_axis_tready && single_pending));
   assign m_axis_tvalid  = !rst && sel_any;
   assign load           = s_axis_tvalid && s_axis_tready;
   assign emit           = m_axis_tvalid && m_axis_tready;

   assign m_axis_tagtime     = beat[m_axis_lane].tagtime;
   assign m_axis_channel     = beat[m_axis_lane].channel;
   assign m_axis_rising_edge = beat[m_axis_lane].rising_edge;

   // A new beat can only arrive as the last pending lane leaves, so load wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending   <= '0;
         tag_count <= '0;
         for (int i = 0; i < int'(NW); i++) begin
            beat[i] <= '0;
         end
      end else begin
         if (load) begin
            pending <= qualified;
            for (int i = 0; i < int'(NW); i++) begin
               beat[i] <= in_tag[i];
            end
         end else if (emit) begin
            pending <= pending & ~sel_onehot;
         end
         if (emit) begin
            tag_count <= tag_count + 32'd1;
         end
      end
   end

endmodule

// File: doc/si_tag_lane_scheduler.md
SI_TAG_LANE_SCHEDULER -- requirements
Module: si_tag_lane_scheduler

Interface
REQ-001 SHALL have parameter NUMBER_OF_WORDS, default 4, number of parallel tag lanes per input beat.
REQ-002 SHALL have parameter CHANNEL_COUNT, default 20, number of internal channels (0-based).
REQ-003 SHALL have parameter LANE_WIDTH, default $clog2(NUMBER_OF_WORDS) (minimum 1), width of the lane index output.
REQ-004 SHALL have clk, input, 1, single clock for all logic.
REQ-005 SHALL have rst, input, 1, reset; one clock, synchronous, active-high.
REQ-006 SHALL have s_axis_tvalid / s_axis_tready, input / output, 1 each, beat handshake.
REQ-007 SHALL have s_axis_tagtime, input, 64 x NUMBER_OF_WORDS, tag times in 1/3 ps.
REQ-008 SHALL have s_axis_channel, input, 5 x NUMBER_OF_WORDS, channel numbers, 0-based.
REQ-009 SHALL have s_axis_rising_edge, input, 1 x NUMBER_OF_WORDS, 1 = rising edge.
REQ-010 SHALL have s_axis_tkeep, input, NUMBER_OF_WORDS, per-lane valid.
REQ-011 SHALL have channel_enable, input, CHANNEL_COUNT, per-channel pass mask.
REQ-012 SHALL have rising_enable / falling_enable, input / input, 1 each, edge-polarity pass.
REQ-013 SHALL have m_axis_tvalid / m_axis_tready, output / input, 1 each, single-tag handshake.
REQ-014 SHALL have m_axis_tagtime / m_axis_channel / m_axis_rising_edge, output, 64 / 5 / 1, selected tag.
REQ-015 SHALL have m_axis_lane, output, LANE_WIDTH, source lane of the emitted tag.
REQ-016 SHALL have tag_count, output, 32, emitted-tag counter.

Function
REQ-017 SHALL hold one beat buffer (tagtime, channel, edge per lane) plus a NUMBER_OF_WORDS-bit pending mask.
REQ-018 Lane i SHALL qualify at load when tkeep[i] is set, channel[i] < CHANNEL_COUNT, channel_enable[channel[i]] is set, and (rising_enable if edge=1, falling_enable if edge=0).
REQ-019 s_axis_tready SHALL equal !rst && (pending==0 || (m_axis_tready && pending has exactly one bit set)), combinationally.
REQ-020 On s_axis_tvalid && s_axis_tready, the buffer SHALL load all lanes, and pending SHALL load the qualified mask.
REQ-021 A beat with qualified mask 0 SHALL be accepted and discarded, with no output tag.
REQ-022 m_axis_tvalid SHALL equal |pending; the selected lane SHALL be the lowest-index set bit of pending.
REQ-023 m_axis_tagtime, m_axis_channel, m_axis_rising_edge and m_axis_lane SHALL come from the selected lane and be stable while m_axis_tvalid && !m_axis_tready.
REQ-024 On m_axis_tvalid && m_axis_tready, the selected pending bit SHALL clear; a simultaneous load (REQ-020) SHALL take precedence over the clear.
REQ-025 First tag latency SHALL be 1 cycle after beat acceptance.
REQ-026 Sustained throughput SHALL be 1 tag/cycle across beat boundaries, with no bubble when m_axis_tready is held high.
REQ-027 Tags SHALL be emitted in ascending lane order within a beat and in beat order across beats.
REQ-028 tag_count SHALL increment by 1 per output handshake and wrap from 0xFFFFFFFF to 0.
REQ-029 Changes to the filter inputs SHALL affect only beats loaded after the change, never already-pending tags.

Reset
REQ-030 While rst=1, the block SHALL clear pending, the buffer, m_axis_lane and tag_count to 0, and drive m_axis_tvalid=0 and s_axis_tready=0.
REQ-031 rst asserted mid-beat SHALL discard all pending tags; the first cycle after deassertion SHALL have s_axis_tready=1 and m_axis_tvalid=0.

Structure
REQ-032 Shared package si_tag_pkg SHALL hold the tag record typedef (tagtime 64, channel 5, rising_edge 1) and the constant TAGTIME_WIDTH=64.
REQ-033 Lowest-set-bit selection SHALL be a sub-module si_lowest_bit_enc (parameter WIDTH; outputs index, any, onehot).

Verification
REQ-034 N=4, tkeep=1111, all channels enabled, m_tready=1 -> lanes 0,1,2,3 out on 4 consecutive cycles; s_tready=1 only in the 4th cycle; tag_count=4.
REQ-035 tkeep=1010, channel_enable excludes lane 3's channel -> exactly one tag (lane 1), s_tready high the same cycle.
REQ-036 Back-to-back beats of tkeep=0001 with m_tready=1 -> one tag per cycle, no bubbles, lane=0 each.
REQ-037 m_tready held low 5 cycles with tkeep=0110 -> lane 1 tag stable 5 cycles, s_tready=0; release -> lanes 1,2 out in order.
REQ-038 rising_enable=0, tkeep=1111, edges=1,0,1,0 -> lanes 1,3 only; a beat with all lanes filtered is accepted, no output.
REQ-039 rst pulsed after lane 0 of a 4-tag beat -> no further tags; tag_count=0; next beat is accepted the cycle after rst falls.
